// File: rtl/frame_loader.sv
// Receive-side framing stage: hunts for a sync byte, converts IMG_SIZE*IMG_SIZE
// pixel bytes to signed fixed point for IFMAP, then verifies a trailing checksum.
module frame_loader #(
   parameter int         DATA_WIDTH   = 16,
   parameter int         FRAC_BITS    = 7,
   parameter int         IMG_SIZE     = 28,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5,
   parameter int         TIMEOUT_CLKS = 100000,
   localparam int        AW           = $clog2(IMG_SIZE*IMG_SIZE)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_dv,
   input  logic [7:0]            rx_byte,
   input  logic                  hold,
   output logic                  wr_en,
   output logic [AW-1:0]         wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  frame_loaded,
   output logic                  frame_error,
   output logic [1:0]            err_code,
   output logic                  busy
);

   localparam int NPIX = IMG_SIZE * IMG_SIZE;
   localparam int GW   = $clog2(TIMEOUT_CLKS + 1);

   localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);
   localparam logic [GW-1:0] GAP_MAX  = GW'(TIMEOUT_CLKS - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PAYLOAD = 2'd1;
   localparam logic [1:0] S_CHECK   = 2'd2;

   localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
   localparam logic [1:0] ERR_CHECKSUM = 2'b10;

   logic [1:0]            state;
   logic [AW-1:0]         pix_cnt;
   logic [7:0]            sum;
   logic [GW-1:0]         gap_cnt;
   logic                  gap_expired;
   logic [DATA_WIDTH-1:0] lut [256];

   // Rounded unsigned-to-fixed conversion, fully resolved at elaboration.
   for (genvar k = 0; k < 256; k++) begin : g_lut
      localparam int VAL = (k * (2 ** FRAC_BITS) + 127) / 255;
      assign lut[k] = DATA_WIDTH'(VAL);
   end

   assign gap_expired = (gap_cnt == GAP_MAX);
   assign busy        = (state != S_IDLE);

   // A byte arriving on the expiry cycle takes priority over the timeout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         pix_cnt      <= '0;
         sum          <= '0;
         gap_cnt      <= '0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         frame_loaded <= 1'b0;
         frame_error  <= 1'b0;
         err_code     <= 2'b00;
      end else begin
         wr_en        <= 1'b0;
         frame_loaded <= 1'b0;
         frame_error  <= 1'b0;
         case (state)
            S_IDLE: begin
               gap_cnt <= '0;
               if (rx_dv && rx_byte == SYNC_BYTE && !hold) begin
                  state   <= S_PAYLOAD;
                  pix_cnt <= '0;
                  sum     <= '0;
               end
            end
            S_PAYLOAD: begin
               if (rx_dv) begin
                  wr_en   <= 1'b1;
                  wr_addr <= pix_cnt;
                  wr_data <= lut[rx_byte];
                  sum     <= sum + rx_byte;
                  gap_cnt <= '0;
                  if (pix_cnt == LAST_PIX) begin
                     pix_cnt <= '0;
                     state   <= S_CHECK;
                  end else begin
                     pix_cnt <= pix_cnt + 1'b1;
                  end
               end else if (gap_expired) begin
                  frame_error <= 1'b1;
                  err_code    <= ERR_TIMEOUT;
                  gap_cnt     <= '0;
                  state       <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            S_CHECK: begin
               if (rx_dv) begin
                  if (rx_byte == sum) begin
                     frame_loaded <= 1'b1;
                  end else begin
                     frame_error <= 1'b1;
                     err_code    <= ERR_CHECKSUM;
                  end
                  gap_cnt <= '0;
                  state   <= S_IDLE;
               end else if (gap_expired) begin
                  frame_error <= 1'b1;
                  err_code    <= ERR_TIMEOUT;
                  gap_cnt     <= '0;
                  state       <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state   <= S_IDLE;
               gap_cnt <= '0;
            end
         endcase
      end
   end

endmodule
